// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state type, the
// default operand width and the bit-counter sizing helper.
package serial_add_ctrl_pkg;

    localparam int unsigned ADD_W = 8;

    // 2'b11 is unused and steers back to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // The counter only has to reach width-1; keep at least one bit for width 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_add_1.sv
// One-bit full adder made of two half-adder stages; the serial sequencer
// reuses this single cell for every bit position.
module add_1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic h0_sum;
    logic h0_carry;
    logic h1_carry;

    // First stage adds the operand bits, second stage folds in the carry.
    always_comb begin
        h0_sum   = a ^ b;
        h0_carry = a & b;
        sum      = h0_sum ^ cin;
        h1_carry = h0_sum & cin;
        cout     = h0_carry | h1_carry;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in on start, feeds one
// bit pair per clock through a shared full adder (LSB first), then pulses done with the result.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_shift;
    logic             accept;
    logic             last_bit;

    add_1 u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bits enter at the MSB so the first (LSB) result bit ends up at bit 0.
    if (WIDTH == 1) begin : g_acc_w1
        assign acc_shift = fa_sum;
    end else begin : g_acc_wn
        assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};
    end

    assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_bit = (state_q == StRun) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = acc_shift;
                c_d    = fa_cout;
                if (last_bit) begin
                    sum_d   = acc_shift;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = accept ? StRun : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Operand capture shares one path for the idle and back-to-back cases.
        if (accept) begin
            a_sh_d = a;
            b_sh_d = b;
            c_d    = cin;
            cnt_d  = '0;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a table of directed vectors, hand-written
// multi-cycle sequences, a WIDTH=1 instance and a random sweep against a+b+cin.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int unsigned vectors;
    int unsigned errors;
    logic [8:0]  held;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; poke >= 0 re-pulses start with a=55 at that RUN cycle.
    task automatic op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      input int poke, input string tag);
        logic [8:0] expv;
        expv  = {1'b0, ta} + {1'b0, tb_} + {8'b0, tc};
        a     = ta;
        b     = tb_;
        cin   = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s busy c%0d", tag, i), busy, 1);
            check($sformatf("%s done low c%0d", tag, i), done, 0);
            check($sformatf("%s held c%0d", tag, i), {cout, sum}, held);
            if (i == poke) begin
                start = 1'b1;
                a     = 8'h55;
            end
            tick();
            start = 1'b0;
        end
        check($sformatf("%s done", tag), done, 1);
        check($sformatf("%s busy end", tag), busy, 0);
        check($sformatf("%s result", tag), {cout, sum}, expv);
        held = expv;
        tick();
        check($sformatf("%s done one-shot", tag), done, 0);
        check($sformatf("%s idle", tag), busy, 0);
        check($sformatf("%s result held", tag), {cout, sum}, held);
    endtask

    initial begin
        vec_t vecs[8];
        vectors = 0;
        errors  = 0;
        held    = '0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        start1  = 1'b0;
        a1      = '0;
        b1      = '0;
        cin1    = 1'b0;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        repeat (2) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        check("reset w1 busy/done/sum/cout", {busy1, done1, sum1, cout1}, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle after reset", busy, 0);

        for (int i = 0; i < 8; i++) begin
            op(vecs[i].a, vecs[i].b, vecs[i].cin, -1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), {cout, sum}, {vecs[i].cout, vecs[i].sum});
        end

        // Start re-pulsed mid-RUN is ignored.
        op(8'h21, 8'h10, 1'b1, 3, "restart");
        check("restart table", {cout, sum}, {1'b0, 8'h32});

        // Back-to-back: start held into DONE with new operands.
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        tick();
        check("b2b first done", done, 1);
        check("b2b first result", {cout, sum}, 9'h003);
        tick();
        start = 1'b0;
        a     = 8'hEE;
        b     = 8'hEE;
        check("b2b second busy", busy, 1);
        check("b2b second done low", done, 0);
        repeat (7) tick();
        check("b2b still busy", busy, 1);
        check("b2b held", {cout, sum}, 9'h003);
        tick();
        check("b2b second done", done, 1);
        check("b2b second result", {cout, sum}, 9'h046);
        held = 9'h046;
        tick();
        check("b2b done one-shot", done, 0);

        // Reset during RUN aborts the operation.
        a     = 8'h0F;
        b     = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst result", {cout, sum}, 0);
        held = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("midrst idle c%0d", i), {busy, done}, 0);
        end
        op(8'h0F, 8'h01, 1'b0, -1, "postrst");

        // WIDTH=1 instance: all operand combinations.
        for (int i = 0; i < 8; i++) begin
            logic [1:0] e1;
            a1     = 1'(i >> 2);
            b1     = 1'(i >> 1);
            cin1   = 1'(i);
            e1     = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check($sformatf("w1 op%0d busy", i), {busy1, done1}, 2'b10);
            tick();
            check($sformatf("w1 op%0d done", i), {busy1, done1}, 2'b01);
            check($sformatf("w1 op%0d result", i), {cout1, sum1}, e1);
            tick();
            check($sformatf("w1 op%0d one-shot", i), done1, 0);
        end

        for (int i = 0; i < 1000; i++) begin
            op(8'($urandom), 8'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
